// File: rtl/ysyx_2022040010_wb_arbiter_pkg.sv
// Shared register-file constants and write-back arbiter port encodings.
package ysyx_2022040010_wb_arbiter_pkg;

  localparam int RegNumLog2 = 5;
  localparam int RegBus     = 64;

  typedef logic [RegNumLog2-1:0] RegAddrBus;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  typedef enum logic {
    WbPort0 = 1'b0,
    WbPort1 = 1'b1
  } wb_port_e;

  localparam int WbStarveDefault = 4;
  localparam int WbCntW          = 4;

endpackage

// File: rtl/ysyx_2022040010_wb_age_cnt.sv
// Saturating wait counter for the low-priority write-back port.
// starved is decoded straight from the registered count, so it never depends on this cycle's grant.
module ysyx_2022040010_wb_age_cnt
  import ysyx_2022040010_wb_arbiter_pkg::*;
#(
  parameter int LIMIT = WbStarveDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic grant,
  output logic starved
);

  localparam logic [WbCntW-1:0] Lim = WbCntW'(LIMIT);

  logic [WbCntW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (grant || !valid) begin
      wait_cnt <= '0;
    end else if (wait_cnt != Lim) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign starved = (wait_cnt == Lim);

endmodule

// File: rtl/ysyx_2022040010_wb_arbiter.sv
// Two-port register-file write-back arbiter: port 0 priority, registered we/waddr/wdata.
// Aging override for port 1 is built only when WB_ARB_AGING_EN is defined.
module ysyx_2022040010_wb_arbiter
  import ysyx_2022040010_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = WbStarveDefault,
  parameter int ADDR_W       = RegNumLog2,
  parameter int DATA_W       = RegBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ready0,
  input  logic              valid1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ready1,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              starved
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..15");
  end

  logic              grant0;
  logic              grant1;
  wb_port_e          sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

`ifdef WB_ARB_AGING_EN
  ysyx_2022040010_wb_age_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_age_cnt (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid1),
    .grant  (grant1),
    .starved(starved)
  );
`else
  assign starved = 1'b0;
`endif

  // Grants are masked while reset is held so no request is acknowledged then.
  assign grant1 = rst && valid1 && (!valid0 || starved);
  assign grant0 = rst && valid0 && !grant1;
  assign ready0 = grant0;
  assign ready1 = grant1;

  assign sel      = grant1 ? WbPort1 : WbPort0;
  assign sel_addr = (sel == WbPort1) ? addr1 : addr0;
  assign sel_data = (sel == WbPort1) ? data1 : data0;

  // x0 writes are handshaked but never reach the regfile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we    <= WriteDisable;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= ((grant0 || grant1) && (sel_addr != '0)) ? WriteEnable : WriteDisable;
      if (grant0 || grant1) begin
        waddr <= sel_addr;
        wdata <= sel_data;
      end
    end
  end

endmodule

// File: doc/ysyx_2022040010_wb_arbiter.md
# ysyx_2022040010_wb_arbiter

Write-back arbiter that shares the single register-file write port between two producers: the in-order execute/write-back pipeline (port 0) and the long-latency unit for load, multiply and divide (port 1). Each port uses a valid/ready handshake. A registered output stage drives the regfile `we`/`waddr`/`wdata` inputs. Port 0 has priority, and an aging counter guarantees port 1 progress.

## Interface
- `STARVE_LIMIT`, 4: cycles port 1 may wait while valid before it overrides port 0; legal range 1..15.
- `ADDR_W`, `RegNumLog2` (5): register index width.
- `DATA_W`, 64 (`RegBus`): register data width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `valid0`  in  1  port 0 write request.
- `addr0`  in  ADDR_W  port 0 destination register.
- `data0`  in  DATA_W  port 0 write data.
- `ready0`  out  1  port 0 accepted this cycle.
- `valid1`, `addr1`, `data1`, `ready1`: same as port 0, for port 1.
- `we`  out  1  registered write enable to the regfile.
- `waddr`  out  ADDR_W  registered write address.
- `wdata`  out  DATA_W  registered write data.
- `starved`  out  1  high while the aging override is active (debug).

## Operation
- Handshake: a transfer occurs when `valid_i && ready_i` at a rising edge.
  - `ready_i` is combinational and equals `grant_i`.
  - At most one grant per cycle; `ready_i` is never high while `valid_i` is low.
  - Requesters hold `valid`, `addr` and `data` stable until accepted.
- Grant rules:
  - `grant1 = valid1 && (!valid0 || starved)`.
  - `grant0 = valid0 && !grant1`.
- Aging counter `wait_cnt`, width 4:
  - Increments when `valid1 && !grant1`.
  - Saturates at `STARVE_LIMIT`.
  - Clears on `grant1`, or when `valid1` is low.
  - `starved = (wait_cnt == STARVE_LIMIT)`.
- Output stage: on every edge, `we <= (grant0 || grant1) && (granted addr != 0)`, and `waddr`/`wdata` load from the granted port.
  - When nothing is granted, `we` drops to 0 and `waddr`/`wdata` hold their previous values.
- Writes to x0 are accepted, with `ready` asserted, and discarded (`we` stays 0).
- There is no backpressure from the regfile, so throughput is one write per cycle.
- Same-address requests on both ports in one cycle: the winner writes first and the loser a later cycle, so the loser's value is final. Ordering correctness is the issuing units' responsibility.

## Timing
- Reset values: `we`=0, `waddr`=0, `wdata`=0, `wait_cnt`=0, `starved`=0. `ready0`/`ready1` follow `valid` combinationally, so they are 0 while no request is presented.
- Latency:
  - A handshake at edge N produces `we`/`waddr`/`wdata` valid from N until N+1.
  - The regfile commits at edge N+1.
  - The regfile's write-through read path makes the data visible to same-cycle readers during that N-to-N+1 window.
- Starvation bound: with `valid1` held, port 1 is granted within `STARVE_LIMIT`+1 cycles of raising `valid1`, regardless of port 0.
- Reset asserted mid-operation:
  - Clears all state immediately, asynchronously; a write registered but not yet committed is lost.
  - `we` is 0 from reset assertion, so no spurious write occurs.
  - Requesters re-issue after `rst` returns high.
- Reset deassertion is synchronised by the reset source; no grant occurs on the first edge after release unless `valid` is high.

## Configuration
- `WB_ARB_AGING_EN` defined: aging counter and `starved` are built as described.
- Undefined:
  - Strict port-0 priority: `grant1 = valid1 && !valid0`.
  - `wait_cnt` is not instantiated and `starved` is tied to 0.
  - `STARVE_LIMIT` is ignored.

## Structure
- Shared defines header holds:
  - `RegAddrBus`, `RegBus`, `RegNumLog2`, `WriteEnable`/`WriteDisable`.
  - The new constants `WbPort0`/`WbPort1` and `WbStarveDefault` (4).
- One natural sub-module, `ysyx_2022040010_wb_age_cnt`: the saturating wait counter with clear, increment and limit compare. It is instantiated only under `WB_ARB_AGING_EN`.
- Grant logic and the output register stay in the top module.

## Test plan
- Reset: hold `rst`=0 with both `valid` high -> `we`=0, `waddr`=0, `wdata`=0, `ready0`=`ready1`=0; release -> the first grant goes to port 0.
- Single write: `valid0`=1, `addr0`=5, `data0`=64'hDEAD_BEEF at edge N -> `ready0`=1 before edge N; from N to N+1, `we`=1, `waddr`=5, `wdata`=64'hDEAD_BEEF.
- x0 drop: `valid1`=1, `addr1`=0, `data1`=64'h1234 -> `ready1`=1, and the next cycle `we`=0.
- Contention with aging (`STARVE_LIMIT`=4): both ports valid continuously -> grants follow the pattern P0,P0,P0,P0,P1 and repeat; `starved`=1 exactly in the P1-grant cycles.
- Macro off, same contention -> port 1 never granted until `valid0` drops; then `ready1`=1 in that same cycle.
- Mid-operation reset: grant at edge N, `rst`=0 asserted between N and N+1 -> `we` falls to 0 immediately and the regfile entry is unchanged.
